priority_mealy_design: RTL and testbench
========================================

Name: priority_mealy_design

Overview:
- Serial running-parity detector built as a 2-state Mealy FSM.
- Consumes one bit `i_x` per clock and drives `o_p` combinationally from the current state and the live `i_x`.
- `o_p` indicates whether the count of 1s is even, counting every bit accepted since reset plus the current `i_x`.
- Used as a leaf block wherever a bit-serial stream needs on-the-fly parity flagging.

Parameters:
- EVEN_PARITY, 1: 1 means `o_p`=1 when the ones count is even; 0 inverts `o_p` (odd-parity flag).
- CNT_W, 8: width of the optional ones counter. Used only when PARITY_COUNT_EN is defined. Legal range 1..32.

Ports:
- i_clk  input  1  system clock; all state updates on the rising edge.
- i_rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
- i_x    input  1  serial data bit, sampled on each rising edge when not in reset.
- o_p    output 1  Mealy parity flag (combinational from state and `i_x`).
- o_ones_cnt  output  CNT_W  count of accepted 1s. Present only with PARITY_COUNT_EN.

Behaviour:
- One clock domain, `i_clk`. The reset is asynchronous and active-low.
- States:
  - S_EVEN: an even number of 1s accepted so far.
  - S_ODD: an odd number of 1s accepted so far.
  - Encode as a 1-bit register; S_EVEN = 0.
- Reset:
  - `i_rst`=0 forces state to S_EVEN immediately, without waiting for a clock edge.
  - The state is held at S_EVEN while `i_rst`=0.
  - Release takes effect at the first rising edge with `i_rst`=1.
- Transitions, evaluated on each rising edge with `i_rst`=1:
  - S_EVEN, `i_x`=0 -> S_EVEN
  - S_EVEN, `i_x`=1 -> S_ODD
  - S_ODD, `i_x`=0 -> S_ODD
  - S_ODD, `i_x`=1 -> S_EVEN
  - Equivalently, next state = state XOR `i_x`.
- Output, purely combinational (Mealy):
  - par_even = NOT(state XOR `i_x`).
  - `o_p` = par_even when EVEN_PARITY=1, otherwise NOT par_even.
  - `o_p` reacts to `i_x` changes within the same cycle, with no register on the output.
- Output value during reset:
  - State is S_EVEN, so `o_p` = NOT `i_x` (EVEN_PARITY=1).
  - With `i_x`=0 in reset, `o_p`=1.
- Latency: zero cycles from `i_x` to `o_p`. The effect of `i_x` on the state is visible one edge later.
- Reset mid-stream: the state is lost immediately and parity restarts from even. There is no partial-cycle memory.
- No X propagation on `o_p` after reset. The default branch of the next-state logic returns to S_EVEN.
- No illegal states exist with 1-bit encoding. If a wider encoding is used, any unused code recovers to S_EVEN on the next edge.

Optional Feature:
- Macro: PARITY_COUNT_EN.
- Defined:
  - Adds output `o_ones_cnt[CNT_W-1:0]`.
  - The counter clears asynchronously to 0 while `i_rst`=0.
  - It increments by 1 on each rising edge where `i_x`=1 and `i_rst`=1.
  - It wraps from 2^CNT_W-1 to 0.
  - Invariant: `o_ones_cnt`[0] equals the state bit (1 = S_ODD).
- Not defined: the port and counter logic are absent. FSM and `o_p` behaviour are identical in both builds.

Test Plan:
1. Reset and hold: drive `i_rst`=0 and `i_x`=0 for 2 cycles -> `o_p`=1 and state S_EVEN. Pulse `i_x`=1 during reset -> `o_p`=0 combinationally, and the state stays S_EVEN after an edge.
2. Release and sequence: release `i_rst`=1, then apply `i_x` = 0,1,1,0,1 on successive edges, checking `o_p` just before each edge.
   - Required `o_p`: 1, 0, 1, 1, 0.
   - Required state after each edge: EVEN, ODD, EVEN, EVEN, ODD.
3. Mealy combinational check: in S_ODD, toggle `i_x` 0->1->0 mid-cycle without a clock edge -> `o_p` follows 0->1->0 immediately and the state is unchanged.
4. Async reset mid-stream: in S_ODD, assert `i_rst`=0 between clock edges -> the state goes to S_EVEN at once and `o_p` = NOT `i_x` before the next edge.
5. Long run: 16 consecutive `i_x`=1 -> `o_p` alternates 0,1,0,1,... and the state ends at S_EVEN. With EVEN_PARITY=0, every `o_p` value is inverted.
6. PARITY_COUNT_EN with CNT_W=2: 5 ones -> `o_ones_cnt` goes 1,2,3,0,1. Bit 0 of `o_ones_cnt` matches the state on every cycle, and reset clears it to 0 asynchronously.

Source files
------------

// File: rtl/priority_mealy_design.sv
`default_nettype none
// ============================================================================
// Module   : priority_mealy_design
// Purpose  : Serial running-parity detector built as a 2-state Mealy FSM.
//            It consumes one bit per clock. The parity flag is combinational
//            from the stored parity state and the live input bit, so it
//            already includes the bit that is currently on i_x.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports    : i_clk      in   1      system clock, rising edge
//            i_rst      in   1      asynchronous reset, active-low
//            i_x        in   1      serial data bit
//            o_p        out  1      parity flag (EVEN_PARITY=1: 1 = even)
//            o_ones_cnt out  CNT_W  accepted-ones counter (PARITY_COUNT_EN)
// Params   : EVEN_PARITY  1 = flag even ones count, 0 = flag odd count
//            CNT_W        ones-counter width, 1..32
// Macro    : PARITY_COUNT_EN  adds the o_ones_cnt output and its counter
// ============================================================================
module priority_mealy_design #(
    parameter int EVEN_PARITY = 1,
    parameter int CNT_W       = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_x,
`ifdef PARITY_COUNT_EN
    output logic [CNT_W-1:0] o_ones_cnt,
`endif
    output logic             o_p
);

    localparam logic [0:0] S_EVEN = 1'b0;
    localparam logic [0:0] S_ODD  = 1'b1;

    // Reject an out-of-range counter width when the design is elaborated.
    if ((CNT_W < 1) || (CNT_W > 32)) begin : g_bad_cnt_w
        $error("priority_mealy_design: CNT_W must be in 1..32");
    end

    logic [0:0] state_q;
    logic [0:0] state_d;
    logic       par_even;

    // Next state is state XOR i_x. Any code outside the two states falls
    // back to S_EVEN.
    always_comb begin
        state_d = S_EVEN;
        case (state_q)
            S_EVEN:  state_d = i_x ? S_ODD  : S_EVEN;
            S_ODD:   state_d = i_x ? S_EVEN : S_ODD;
            default: state_d = S_EVEN;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= S_EVEN;
        end else begin
            state_q <= state_d;
        end
    end

    // Mealy output: the ones count includes the bit that is currently on
    // i_x, so the flag follows i_x inside the cycle with no register.
    assign par_even = ~(state_q[0] ^ i_x);

    if (EVEN_PARITY != 0) begin : g_even_flag
        assign o_p = par_even;
    end else begin : g_odd_flag
        assign o_p = ~par_even;
    end

`ifdef PARITY_COUNT_EN
    logic [CNT_W-1:0] ones_cnt_q;

    // Wraps naturally at 2^CNT_W. Bit 0 always tracks the parity state.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            ones_cnt_q <= '0;
        end else if (i_x) begin
            ones_cnt_q <= ones_cnt_q + CNT_W'(1);
        end
    end

    assign o_ones_cnt = ones_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_priority_mealy_design.sv
`default_nettype none
// ============================================================================
// Module   : tb_priority_mealy_design
// Purpose  : Self-checking bench for priority_mealy_design. It uses a
//            directed vector table and hand-written corner sequences, then
//            random traffic checked against a ones-count reference model.
// Revision : 1.0 - initial release
// Macro    : PARITY_COUNT_EN  also checks the ones counter (CNT_W = 2)
// ============================================================================
module tb_priority_mealy_design;

    logic clk;
    logic i_rst;
    logic i_x;
    logic p_even;
    logic p_odd;

    int total = 0;
    int bad   = 0;

    // Reference model: the number of ones accepted since the last reset.
    int ones = 0;

`ifdef PARITY_COUNT_EN
    logic [1:0] cnt_even;
    logic [1:0] cnt_odd;
`endif

    priority_mealy_design #(.EVEN_PARITY(1), .CNT_W(2)) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_x        (i_x),
`ifdef PARITY_COUNT_EN
        .o_ones_cnt (cnt_even),
`endif
        .o_p        (p_even)
    );

    priority_mealy_design #(.EVEN_PARITY(0), .CNT_W(2)) dut_odd (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_x        (i_x),
`ifdef PARITY_COUNT_EN
        .o_ones_cnt (cnt_odd),
`endif
        .o_p        (p_odd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Compares every output with the reference model for the live i_x.
    task automatic check_model(input string name);
        logic exp_even;
        exp_even = (((ones + int'(i_x)) % 2) == 0);
        check({name, ".p"},     {31'd0, p_even}, {31'd0, exp_even});
        check({name, ".p_odd"}, {31'd0, p_odd},  {31'd0, ~exp_even});
`ifdef PARITY_COUNT_EN
        check({name, ".cnt"},     {30'd0, cnt_even}, 32'(ones % 4));
        check({name, ".cnt_odd"}, {30'd0, cnt_odd},  32'(ones % 4));
`endif
    endtask

    // Drive one bit mid-cycle, check it, then let one rising edge take it.
    task automatic apply(input logic x, input string name);
        i_x = x;
        #2;
        check_model(name);
        @(posedge clk);
        if (i_rst) ones += int'(x);
        #1;
    endtask

    typedef struct {
        logic x;
        logic exp_p;
    } vec_t;

    vec_t vecs[5];

`ifdef PARITY_COUNT_EN
    logic [1:0] exp_cnt [5];
`endif

    initial begin
        vecs[0] = '{1'b0, 1'b1};
        vecs[1] = '{1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b1};
        vecs[3] = '{1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0};

        // Reset and hold.
        i_rst = 1'b0;
        i_x   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_p", {31'd0, p_even}, 32'd1);
        check("rst_hold_p_odd", {31'd0, p_odd}, 32'd0);
`ifdef PARITY_COUNT_EN
        check("rst_hold_cnt", {30'd0, cnt_even}, 32'd0);
`endif
        i_x = 1'b1;
        #1;
        check("rst_x1_p", {31'd0, p_even}, 32'd0);
        @(posedge clk);
        #1;
        i_x = 1'b0;
        #1;
        check("rst_state_held", {31'd0, p_even}, 32'd1);
        ones = 0;

        // Release, then apply the directed vector table.
        @(posedge clk);
        #1;
        i_rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            i_x = vecs[i].x;
            #2;
            check($sformatf("vec%0d_p", i), {31'd0, p_even}, {31'd0, vecs[i].exp_p});
            check($sformatf("vec%0d_p_odd", i), {31'd0, p_odd}, {31'd0, ~vecs[i].exp_p});
            check_model($sformatf("vec%0d_model", i));
            @(posedge clk);
            ones += int'(vecs[i].x);
            #1;
        end

        // Now in S_ODD: the flag must follow i_x within the cycle.
        i_x = 1'b0;
        #1;
        check("mealy_x0_p", {31'd0, p_even}, 32'd0);
        i_x = 1'b1;
        #1;
        check("mealy_x1_p", {31'd0, p_even}, 32'd1);
        check("mealy_x1_p_odd", {31'd0, p_odd}, 32'd0);
        i_x = 1'b0;
        #1;
        check("mealy_back_p", {31'd0, p_even}, 32'd0);

        // Asynchronous reset between edges, still in S_ODD.
        i_rst = 1'b0;
        ones  = 0;
        #1;
        check("async_rst_p", {31'd0, p_even}, 32'd1);
`ifdef PARITY_COUNT_EN
        check("async_rst_cnt", {30'd0, cnt_even}, 32'd0);
`endif
        i_x = 1'b1;
        #1;
        check("async_rst_x1_p", {31'd0, p_even}, 32'd0);
        @(posedge clk);
        #1;
        i_rst = 1'b1;
        i_x   = 1'b0;

        // Long run of ones: the flag alternates 0,1,0,1,...
        for (int k = 0; k < 16; k++) begin
            i_x = 1'b1;
            #2;
            check($sformatf("run%0d_p", k), {31'd0, p_even}, {31'd0, (k % 2) == 1});
            check_model($sformatf("run%0d", k));
            @(posedge clk);
            ones++;
            #1;
        end
        i_x = 1'b0;
        #1;
        check("run_end_even", {31'd0, p_even}, 32'd1);

`ifdef PARITY_COUNT_EN
        // 2-bit counter: five ones give 1,2,3,0,1, then an async clear.
        exp_cnt[0] = 2'd1;
        exp_cnt[1] = 2'd2;
        exp_cnt[2] = 2'd3;
        exp_cnt[3] = 2'd0;
        exp_cnt[4] = 2'd1;
        i_rst = 1'b0;
        ones  = 0;
        #1;
        i_rst = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            i_x = 1'b1;
            @(posedge clk);
            ones++;
            #1;
            i_x = 1'b0;
            #1;
            check($sformatf("cnt%0d", k), {30'd0, cnt_even}, {30'd0, exp_cnt[k]});
            check($sformatf("cnt%0d_bit0", k), {31'd0, cnt_even[0]}, {31'd0, ~p_even});
        end
        i_rst = 1'b0;
        ones  = 0;
        #1;
        check("cnt_async_clear", {30'd0, cnt_even}, 32'd0);
        @(posedge clk);
        #1;
        i_rst = 1'b1;
`endif

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                i_x   = 1'($urandom_range(0, 1));
                i_rst = 1'b0;
                ones  = 0;
                #1;
                check_model($sformatf("rnd%0d_rst", i));
                @(posedge clk);
                #1;
                i_rst = 1'b1;
            end else begin
                apply(1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
